// File: rtl/linear_network_multicast_pipe.sv
// rtl/linear_network_multicast_pipe.sv - elastic multicast pipeline, one register stage per node
// A packet walks the chain and drops a copy at every node named in its destination bitmask.
module linear_network_multicast_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_NODE   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_en,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [DATA_WIDTH-1:0]          i_data_bus,
    input  logic [NUM_NODE-1:0]            i_dest_mask,
    output logic [NUM_NODE-1:0]            o_valid,
    input  logic [NUM_NODE-1:0]            i_ready,
    output logic [NUM_NODE*DATA_WIDTH-1:0] o_data_bus,
    output logic                           o_busy
);

    logic [NUM_NODE-1:0]   r_valid;
    logic [DATA_WIDTH-1:0] r_data [NUM_NODE];
    logic [NUM_NODE-1:0]   r_mask [NUM_NODE];

    logic [NUM_NODE-1:0]   w_loc, w_fwd, w_loc_done, w_fwd_done, w_empties, w_load;
    logic [NUM_NODE:0]     w_acc;
    logic [DATA_WIDTH-1:0] w_in_data [NUM_NODE];
    logic [NUM_NODE-1:0]   w_in_mask [NUM_NODE];
    logic [NUM_NODE-1:0]   w_keep    [NUM_NODE];

    // Bits strictly above position k: the destinations still downstream of stage k.
    function automatic logic [NUM_NODE-1:0] hi_bits(input int k);
        logic [NUM_NODE-1:0] m;
        for (int j = 0; j < NUM_NODE; j++) begin
            m[j] = (j > k);
        end
        return m;
    endfunction

    // Accept ripples from tail to head so a stage that empties this cycle can reload at once.
    always_comb begin
        w_loc      = '0;
        w_fwd      = '0;
        w_loc_done = '0;
        w_fwd_done = '0;
        w_empties  = '0;
        w_acc      = '0;
        for (int k = NUM_NODE - 1; k >= 0; k--) begin
            w_loc[k]      = r_valid[k] & r_mask[k][k];
            w_fwd[k]      = r_valid[k] & (|(r_mask[k] & hi_bits(k)));
            w_loc_done[k] = i_en & w_loc[k] & i_ready[k];
            w_fwd_done[k] = i_en & w_fwd[k] & w_acc[k+1];
            w_empties[k]  = (~w_loc[k] | w_loc_done[k]) & (~w_fwd[k] | w_fwd_done[k]);
            w_acc[k]      = i_en & (~r_valid[k] | w_empties[k]);
        end
    end

    always_comb begin
        w_load       = '0;
        w_in_data[0] = i_data_bus;
        w_in_mask[0] = i_dest_mask;
        w_load[0]    = i_valid & w_acc[0] & (|i_dest_mask);
        for (int k = 1; k < NUM_NODE; k++) begin
            w_load[k]    = w_fwd_done[k-1];
            w_in_data[k] = r_data[k-1];
            w_in_mask[k] = r_mask[k-1] & hi_bits(k - 1);
        end
        for (int k = 0; k < NUM_NODE; k++) begin
            w_keep[k] = r_mask[k];
            if (w_loc_done[k]) begin
                w_keep[k][k] = 1'b0;
            end
            if (w_fwd_done[k]) begin
                w_keep[k] = w_keep[k] & ~hi_bits(k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int k = 0; k < NUM_NODE; k++) begin
                r_data[k] <= '0;
                r_mask[k] <= '0;
            end
        end else if (i_en) begin
            for (int k = 0; k < NUM_NODE; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= 1'b1;
                    r_data[k]  <= w_in_data[k];
                    r_mask[k]  <= w_in_mask[k];
                end else if (r_valid[k] & w_empties[k]) begin
                    r_valid[k] <= 1'b0;
                    r_mask[k]  <= '0;
                end else if (r_valid[k]) begin
                    r_mask[k]  <= w_keep[k];
                end
            end
        end
    end

    always_comb begin
        o_ready    = w_acc[0] & ~rst;
        o_valid    = {NUM_NODE{i_en}} & w_loc;
        o_busy     = |r_valid;
        o_data_bus = '0;
        for (int k = 0; k < NUM_NODE; k++) begin
            if (o_valid[k]) begin
                o_data_bus[k*DATA_WIDTH +: DATA_WIDTH] = r_data[k];
            end
        end
    end

endmodule

// File: tb/tb_linear_network_multicast_pipe.sv
// tb/tb_linear_network_multicast_pipe.sv - directed vector bench for linear_network_multicast_pipe
module tb_linear_network_multicast_pipe;

    localparam int DW = 32;
    localparam int NN = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           i_en = 1'b1;
    logic           i_valid = 1'b0;
    logic           o_ready;
    logic [DW-1:0]  i_data_bus = '0;
    logic [NN-1:0]  i_dest_mask = '0;
    logic [NN-1:0]  o_valid;
    logic [NN-1:0]  i_ready = '1;
    logic [NN*DW-1:0] o_data_bus;
    logic           o_busy;

    int checks = 0;
    int failures = 0;

    linear_network_multicast_pipe #(.DATA_WIDTH(DW), .NUM_NODE(NN)) dut (
        .clk(clk), .rst(rst), .i_en(i_en), .i_valid(i_valid), .o_ready(o_ready),
        .i_data_bus(i_data_bus), .i_dest_mask(i_dest_mask), .o_valid(o_valid),
        .i_ready(i_ready), .o_data_bus(o_data_bus), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           rst;
        logic           en;
        logic           vld;
        logic [DW-1:0]  data;
        logic [NN-1:0]  mask;
        logic [NN-1:0]  rdy;
        logic [NN-1:0]  ev;
        logic           er;
        logic           eb;
        logic [NN*DW-1:0] ebus;
    } vec_t;

    vec_t vecs[$];

    localparam logic [DW-1:0] Z = 32'h0;
    localparam logic [DW-1:0] A = 32'hAAAAAAAA;
    localparam logic [DW-1:0] B = 32'hBBBBBBBB;
    localparam logic [DW-1:0] C = 32'hCCCCCCCC;
    localparam logic [DW-1:0] D = 32'hDDDDDDDD;
    localparam logic [DW-1:0] P = 32'h11111111;
    localparam logic [DW-1:0] Q = 32'h22222222;
    localparam logic [DW-1:0] R = 32'h33333333;
    localparam logic [DW-1:0] S = 32'h44444444;

    task automatic add(input logic r, input logic en, input logic vld, input logic [DW-1:0] data,
                       input logic [NN-1:0] mask, input logic [NN-1:0] rdy, input logic [NN-1:0] ev,
                       input logic er, input logic eb, input logic [DW-1:0] s3, input logic [DW-1:0] s2,
                       input logic [DW-1:0] s1, input logic [DW-1:0] s0);
        vec_t v;
        v.rst = r; v.en = en; v.vld = vld; v.data = data; v.mask = mask; v.rdy = rdy;
        v.ev = ev; v.er = er; v.eb = eb; v.ebus = {s3, s2, s1, s0};
        vecs.push_back(v);
    endtask

    task automatic chk1(input string name, input int row, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row%0d actual=%b expected=%b", name, row, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int row, input logic [NN-1:0] ev,
                           input logic er, input logic eb, input logic [NN*DW-1:0] ebus);
        checks++;
        if (o_valid !== ev) begin
            failures++;
            $display("FAIL %s_o_valid row%0d actual=%b expected=%b", tag, row, o_valid, ev);
        end
        chk1({tag, "_o_ready"}, row, o_ready, er);
        chk1({tag, "_o_busy"}, row, o_busy, eb);
        checks++;
        if (o_data_bus !== ebus) begin
            failures++;
            $display("FAIL %s_o_data_bus row%0d actual=%h expected=%h", tag, row, o_data_bus, ebus);
        end
    endtask

    initial begin
        // reset held with a broadcast packet presented
        add(1,1,1,A,4'b1111,4'b1111, 4'b0000,0,0, Z,Z,Z,Z);
        add(1,1,1,A,4'b1111,4'b1111, 4'b0000,0,0, Z,Z,Z,Z);
        add(0,1,0,Z,4'b0000,4'b1111, 4'b0000,1,0, Z,Z,Z,Z);
        // unicast to node 2
        add(0,1,1,A,4'b0100,4'b1111, 4'b0000,1,0, Z,Z,Z,Z);
        add(0,1,0,Z,4'b0000,4'b1111, 4'b0000,1,1, Z,Z,Z,Z);
        add(0,1,0,Z,4'b0000,4'b1111, 4'b0000,1,1, Z,Z,Z,Z);
        add(0,1,0,Z,4'b0000,4'b1111, 4'b0100,1,1, Z,A,Z,Z);
        add(0,1,0,Z,4'b0000,4'b1111, 4'b0000,1,0, Z,Z,Z,Z);
        // broadcast streaming A..D
        add(0,1,1,A,4'b1111,4'b1111, 4'b0000,1,0, Z,Z,Z,Z);
        add(0,1,1,B,4'b1111,4'b1111, 4'b0001,1,1, Z,Z,Z,A);
        add(0,1,1,C,4'b1111,4'b1111, 4'b0011,1,1, Z,Z,A,B);
        add(0,1,1,D,4'b1111,4'b1111, 4'b0111,1,1, Z,A,B,C);
        add(0,1,0,Z,4'b0000,4'b1111, 4'b1111,1,1, A,B,C,D);
        add(0,1,0,Z,4'b0000,4'b1111, 4'b1110,1,1, B,C,D,Z);
        add(0,1,0,Z,4'b0000,4'b1111, 4'b1100,1,1, C,D,Z,Z);
        add(0,1,0,Z,4'b0000,4'b1111, 4'b1000,1,1, D,Z,Z,Z);
        add(0,1,0,Z,4'b0000,4'b1111, 4'b0000,1,0, Z,Z,Z,Z);
        // backpressure on node 1
        add(0,1,1,P,4'b0011,4'b1111, 4'b0000,1,0, Z,Z,Z,Z);
        add(0,1,1,Q,4'b0011,4'b1101, 4'b0001,1,1, Z,Z,Z,P);
        add(0,1,0,Z,4'b0000,4'b1101, 4'b0011,0,1, Z,Z,P,Q);
        add(0,1,0,Z,4'b0000,4'b1101, 4'b0010,0,1, Z,Z,P,Z);
        add(0,1,0,Z,4'b0000,4'b1111, 4'b0010,1,1, Z,Z,P,Z);
        add(0,1,0,Z,4'b0000,4'b1111, 4'b0010,1,1, Z,Z,Q,Z);
        add(0,1,0,Z,4'b0000,4'b1111, 4'b0000,1,0, Z,Z,Z,Z);
        // enable freeze with the packet in stage 1
        add(0,1,1,R,4'b1010,4'b1111, 4'b0000,1,0, Z,Z,Z,Z);
        add(0,1,0,Z,4'b0000,4'b1111, 4'b0000,1,1, Z,Z,Z,Z);
        add(0,0,0,Z,4'b0000,4'b1111, 4'b0000,0,1, Z,Z,Z,Z);
        add(0,0,0,Z,4'b0000,4'b1111, 4'b0000,0,1, Z,Z,Z,Z);
        add(0,1,0,Z,4'b0000,4'b1111, 4'b0010,1,1, Z,Z,R,Z);
        add(0,1,0,Z,4'b0000,4'b1111, 4'b0000,1,1, Z,Z,Z,Z);
        add(0,1,0,Z,4'b0000,4'b1111, 4'b1000,1,1, R,Z,Z,Z);
        add(0,1,0,Z,4'b0000,4'b1111, 4'b0000,1,0, Z,Z,Z,Z);
        // zero mask is accepted and dropped
        add(0,1,1,S,4'b0000,4'b1111, 4'b0000,1,0, Z,Z,Z,Z);
        add(0,1,0,Z,4'b0000,4'b1111, 4'b0000,1,0, Z,Z,Z,Z);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rst         = vecs[i].rst;
            i_en        = vecs[i].en;
            i_valid     = vecs[i].vld;
            i_data_bus  = vecs[i].data;
            i_dest_mask = vecs[i].mask;
            i_ready     = vecs[i].rdy;
            #1;
            chk_all("vec", i, vecs[i].ev, vecs[i].er, vecs[i].eb, vecs[i].ebus);
        end

        // asynchronous reset pulse with a packet sitting in stage 2
        @(posedge clk);
        #1;
        i_valid = 1'b1; i_data_bus = 32'h55555555; i_dest_mask = 4'b1000;
        @(posedge clk);
        #1;
        i_valid = 1'b0; i_dest_mask = 4'b0000; i_data_bus = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk_all("pre_rst", 0, 4'b0000, 1'b1, 1'b1, '0);
        #2;
        rst = 1'b1;
        #1;
        chk_all("in_rst", 0, 4'b0000, 1'b0, 1'b0, '0);
        #2;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #2;
            chk_all("post_rst", c, 4'b0000, 1'b1, 1'b0, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
